// File: rtl/unidade_muldiv_if.sv
// Operand, result and handshake bundle between the control/register file side and the mul/div unit.
interface unidade_muldiv_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned REGBITS = 4
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [REGBITS-1:0] regDest;
    logic               busy;
    logic               done;
    logic               RW;
    logic [REGBITS-1:0] regC;
    logic [WIDTH-1:0]   dado;
    logic               divZero;

    modport master (
        output start, op, opA, opB, regDest,
        input  busy, done, RW, regC, dado, divZero
    );

    modport slave (
        input  start, op, opA, opB, regDest,
        output busy, done, RW, regC, dado, divZero
    );
endinterface

// File: rtl/unidade_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one bit per cycle,
// returning its result to the register file as a single-cycle write strobe.
module unidade_muldiv #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned REGBITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    unidade_muldiv_if.slave bus
);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH:0]       hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [REGBITS-1:0]   dest_q, dest_d;
    logic [WIDTH-1:0]     dado_q, dado_d;
    logic [REGBITS-1:0]   regc_q, regc_d;
    logic                 divzero_q, divzero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_fits;

    // hi:lo is the partial product (mul) or remainder:quotient pair (div); b is multiplicand/divisor
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dest_d    = dest_q;
        dado_d    = dado_q;
        regc_d    = regc_q;
        divzero_d = divzero_q;

        mul_sum   = hi_q + (WIDTH+1)'(lo_q[0] ? b_q : '0);
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, b_q});

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    b_d    = bus.op[1] ? bus.opB : bus.opA;
                    lo_d   = bus.op[1] ? bus.opA : bus.opB;
                    hi_d   = '0;
                    cnt_d  = '0;
                    dest_d = bus.regDest;
                    if (bus.op[1] && (bus.opB == '0)) begin
                        state_d   = DONE;
                        dado_d    = bus.op[0] ? bus.opA : '1;
                        regc_d    = bus.regDest;
                        divzero_d = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == CNTW'(WIDTH)) begin
                    // low word is product-low/quotient, high word is product-high/remainder
                    state_d   = DONE;
                    dado_d    = op_q[0] ? hi_q[WIDTH-1:0] : lo_q;
                    regc_d    = dest_q;
                    divzero_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                    if (op_q[1]) begin
                        hi_d = div_fits ? (div_shift - {1'b0, b_q}) : div_shift;
                        lo_d = {lo_q[WIDTH-2:0], div_fits};
                    end else begin
                        hi_d = {1'b0, mul_sum[WIDTH:1]};
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dest_q    <= '0;
            dado_q    <= '0;
            regc_q    <= '0;
            divzero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dest_q    <= dest_d;
            dado_q    <= dado_d;
            regc_q    <= regc_d;
            divzero_q <= divzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.RW      = done_q;
    assign bus.regC    = regc_q;
    assign bus.dado    = dado_q;
    assign bus.divZero = divzero_q;
endmodule

// File: tb/tb_unidade_muldiv.sv
// Self-checking bench for unidade_muldiv: directed cases, random ops against an arithmetic model,
// back-to-back acceptance and mid-operation reset.
module tb_unidade_muldiv;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    unidade_muldiv_if #(.WIDTH(16), .REGBITS(4)) bus();

    unidade_muldiv #(.WIDTH(16), .REGBITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            2'd0:    return p[15:0];
            2'd1:    return p[31:16];
            2'd2:    return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return (b == 16'd0) ? a : a % b;
        endcase
    endfunction

    // Issues one request, then waits (bounded) for done; lat counts edges after the accepting edge.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] rd, output int lat);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b; bus.regDest = rd;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 2'($urandom); bus.opA = 16'($urandom); bus.opB = 16'($urandom);
        bus.regDest = 4'($urandom);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'd0; bus.opA = '0; bus.opB = '0; bus.regDest = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.RW, bus.divZero, bus.regC, bus.dado} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b RW=%b dz=%b regC=%h dado=%h required all zero",
                     bus.busy, bus.done, bus.RW, bus.divZero, bus.regC, bus.dado);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [9] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
        logic [15:0] as  [9] = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 16'd1000, 16'd1000, 16'h0005, 16'h00AB, 16'h00AB};
        logic [15:0] bs  [9] = '{16'h0010, 16'h0010, 16'hFFFF, 16'hFFFF, 16'd7, 16'd7, 16'h0009, 16'h0000, 16'h0000};
        logic [15:0] exp [9] = '{16'h2340, 16'h0001, 16'h0001, 16'hFFFE, 16'h008E, 16'h0006, 16'h0000, 16'hFFFF, 16'h00AB};
        logic        dz  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        int exp_lat;
        for (int i = 0; i < 9; i++) begin
            logic [3:0] rd;
            rd = (i == 0) ? 4'd5 : 4'(i + 3);
            exp_lat = dz[i] ? 0 : 17;
            run_op(ops[i], as[i], bs[i], rd, lat);
            n_cmp++;
            if (lat !== exp_lat) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, exp_lat);
            end
            n_cmp++;
            if (bus.dado !== exp[i]) begin
                n_err++;
                $display("FAIL dir%0d_dado: got %h required %h", i, bus.dado, exp[i]);
            end
            n_cmp++;
            if ({bus.RW, bus.busy, bus.regC, bus.divZero} !== {1'b1, 1'b1, rd, dz[i]}) begin
                n_err++;
                $display("FAIL dir%0d_flags: got RW=%b busy=%b regC=%h dz=%b required RW=1 busy=1 regC=%h dz=%b",
                         i, bus.RW, bus.busy, bus.regC, bus.divZero, rd, dz[i]);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        run_op(2'd0, 16'h0003, 16'h0005, 4'd9, lat);
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.done, bus.RW, bus.busy, bus.dado, bus.regC} !== {3'b000, 16'h000F, 4'd9}) begin
            n_err++;
            $display("FAIL hold_after_done: got done=%b RW=%b busy=%b dado=%h regC=%h required 0 0 0 000f 9",
                     bus.done, bus.RW, bus.busy, bus.dado, bus.regC);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [15:0] a, b, e;
            logic [3:0]  rd;
            op = 2'($urandom);
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 15));
            rd = 4'($urandom);
            e  = model(op, a, b);
            run_op(op, a, b, rd, lat);
            n_cmp++;
            if ({bus.dado, bus.regC, bus.RW} !== {e, rd, 1'b1}) begin
                n_err++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got dado=%h regC=%h RW=%b lat=%0d required dado=%h regC=%h RW=1",
                         i, op, a, b, bus.dado, bus.regC, bus.RW, lat, e, rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op1, op2;
        logic [15:0] a1, b1, a2, b2, e1, e2;
        int got, guard, rw_cnt;
        bit busy_low_seen;
        op1 = 2'($urandom); a1 = 16'($urandom); b1 = 16'($urandom) | 16'd1;
        op2 = 2'($urandom); a2 = 16'($urandom); b2 = 16'($urandom) | 16'd1;
        e1 = model(op1, a1, b1);
        e2 = model(op2, a2, b2);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op1; bus.opA = a1; bus.opB = b1; bus.regDest = 4'd1;
        @(posedge clk); #1;
        got = 0; guard = 0; rw_cnt = 0; busy_low_seen = 1'b0;
        while (got < 2 && guard < 100) begin
            if (bus.RW) begin
                rw_cnt++;
                n_cmp++;
                if (bus.dado !== ((got == 0) ? e1 : e2)) begin
                    n_err++;
                    $display("FAIL b2b_result%0d: got %h required %h", got, bus.dado, (got == 0) ? e1 : e2);
                end
                got++;
                if (got == 1) begin
                    bus.op = op2; bus.opA = a2; bus.opB = b2; bus.regDest = 4'd2;
                end else begin
                    bus.start = 1'b0;
                end
            end else if (got == 0) begin
                bus.op = 2'($urandom); bus.opA = 16'($urandom); bus.opB = 16'($urandom);
                bus.regDest = 4'($urandom);
            end
            if (got == 1 && !bus.busy) busy_low_seen = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        bus.start = 1'b0;
        n_cmp++;
        if (rw_cnt !== 2) begin
            n_err++;
            $display("FAIL b2b_rw_pulses: got %0d required 2", rw_cnt);
        end
        n_cmp++;
        if (busy_low_seen !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_busy_gap: got busy_low_seen=%b required 1", busy_low_seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat, rw_seen;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'd0; bus.opA = 16'h1234; bus.opB = 16'h5678; bus.regDest = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.RW, bus.divZero, bus.regC, bus.dado} !== 24'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got busy=%b done=%b RW=%b dz=%b regC=%h dado=%h required all zero",
                     bus.busy, bus.done, bus.RW, bus.divZero, bus.regC, bus.dado);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rw_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.RW || bus.busy) rw_seen++;
        end
        n_cmp++;
        if (rw_seen !== 0) begin
            n_err++;
            $display("FAIL midreset_no_strobe: got %0d active cycles required 0", rw_seen);
        end
        run_op(2'd0, 16'd3, 16'd4, 4'd3, lat);
        n_cmp++;
        if ({bus.dado, bus.RW} !== {16'h000C, 1'b1} || lat !== 17) begin
            n_err++;
            $display("FAIL midreset_fresh_mul: got dado=%h RW=%b lat=%0d required 000c 1 17", bus.dado, bus.RW, lat);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
